// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
//
// Shared definitions for the instruction-fetch stage:
//   - fetch_state_t : FETCH / HOLD / DRAIN states of the fetch FSM
//   - NOP_INST      : all-zero instruction used for IF/ID bubbles
//   - PC_STEP_DEF   : default byte increment per instruction
//   - RESET_PC_DEF  : default PC after reset
//   - issues_request() : whether a state drives a live fetch request
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

    // FETCH : normal streaming, request outstanding for the current pc
    // HOLD  : a word was accepted under freeze and is parked until decode frees
    // DRAIN : a request to the pre-redirect address is still in flight
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam int          PC_STEP_DEF  = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    // HOLD is the only state in which memory is left idle.
    function automatic logic issues_request(input fetch_state_t s);
        return (s != ST_HOLD);
    endfunction

endpackage : if_fetch_unit_pkg

// File: rtl/if_fetch_unit_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if_id_reg
//
// IF/ID pipeline register: holds the PC+step, the instruction word and a valid
// flag for the decode stage.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low clear (all fields to zero)
//   load       in   write {load_pc, load_inst, valid=1}
//   bubble     in   write a NOP with valid=0, keep pc (wins over load)
//   load_pc    in   PC value to record on load (PC of instruction + step)
//   load_inst  in   instruction word to record on load
//   pc         out  registered PC+step of the held instruction
//   inst       out  registered instruction
//   valid      out  register holds a real instruction
// With neither load nor bubble the register holds its contents.
// -----------------------------------------------------------------------------
module if_fetch_unit_if_id_reg
    import if_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [DATA_W-1:0] load_inst,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] inst,
    output logic              valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc    <= '0;
            inst  <= DATA_W'(NOP_INST);
            valid <= 1'b0;
        end else if (bubble) begin
            // A bubble leaves pc alone so decode still sees the last PC.
            inst  <= DATA_W'(NOP_INST);
            valid <= 1'b0;
        end else if (load) begin
            pc    <= load_pc;
            inst  <= load_inst;
            valid <= 1'b1;
        end
    end

endmodule : if_fetch_unit_if_id_reg

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage. Owns the PC, issues byte addresses to instruction
// memory, accepts returned words and loads them into the IF/ID register.
// Supports hazard freeze, branch redirect and multi-cycle memories.
//
// Memory handshake: imem_req is high whenever the unit wants the word at
// imem_adrs (= pc). imem_rdy high in a cycle means imem_inst is the word for
// the address currently presented; the unit consumes it on that clock edge.
// Memory must not return data while imem_req is low.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   freeze        in   hazard stall from ID: hold pc and IF/ID
//   branch_taken  in   redirect request from ID (beats freeze)
//   branch_addr   in   redirect target byte address (bits [1:0] ignored)
//   imem_req      out  fetch request valid (registered, Moore)
//   imem_adrs     out  fetch byte address, always equal to pc
//   imem_rdy      in   imem_inst valid for imem_adrs this cycle
//   imem_inst     in   returned instruction
//   if_pc         out  PC+PC_STEP of the instruction in IF/ID
//   if_inst       out  instruction in IF/ID
//   if_valid      out  IF/ID holds a real instruction
//   fetch_cnt     out  (IF_PERF_CNT_EN only) valid IF/ID loads, wraps
//   stall_cnt     out  (IF_PERF_CNT_EN only) freeze-or-DRAIN cycles, wraps
//   dbg_state     out  current FSM state (fetch_state_t encoding)
//
// Build option: define IF_PERF_CNT_EN to add fetch_cnt / stall_cnt.
// -----------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                PC_STEP  = PC_STEP_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_adrs,
    input  logic              imem_rdy,
    input  logic [DATA_W-1:0] imem_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_valid,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt,
`endif
    output logic [1:0]        dbg_state
);

    // Instructions are word aligned: the low two address bits are always 0.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] br_target;
    logic [DATA_W-1:0] hold_inst;

    logic              id_load;
    logic              id_bubble;
    logic [DATA_W-1:0] id_inst;

    assign pc_next   = pc + ADDR_W'(PC_STEP);   // wraps modulo 2^ADDR_W
    assign br_target = branch_addr & ALIGN_MASK;

    assign imem_adrs = pc;
    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // IF/ID write controls. A branch always writes a bubble, even under freeze.
    // In DRAIN the register already holds the bubble from the redirect, so it
    // is simply left alone; the stale response is never loaded.
    // -------------------------------------------------------------------------
    always_comb begin
        id_load   = 1'b0;
        id_bubble = 1'b0;
        id_inst   = imem_inst;
        if (branch_taken) begin
            id_bubble = 1'b1;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!freeze) begin
                        if (imem_rdy) id_load   = 1'b1;
                        else          id_bubble = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!freeze) begin
                        id_load = 1'b1;
                        id_inst = hold_inst;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Fetch FSM and PC. imem_req is registered alongside the state so it is a
    // clean Moore output: low exactly while in HOLD.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC & ALIGN_MASK;
            hold_inst <= '0;
            imem_req  <= issues_request(ST_FETCH);
        end else begin
            case (state)
                ST_FETCH: begin
                    if (branch_taken) begin
                        pc <= br_target;
                        // Without rdy the old request is still in flight, so
                        // its eventual response must be thrown away.
                        if (!imem_rdy) begin
                            state    <= ST_DRAIN;
                            imem_req <= issues_request(ST_DRAIN);
                        end
                    end else if (freeze) begin
                        // Take the word now so memory is free; decode gets it
                        // once freeze drops.
                        if (imem_rdy) begin
                            hold_inst <= imem_inst;
                            state     <= ST_HOLD;
                            imem_req  <= issues_request(ST_HOLD);
                        end
                    end else if (imem_rdy) begin
                        pc <= pc_next;
                    end
                end
                ST_HOLD: begin
                    if (branch_taken) begin
                        pc       <= br_target;
                        state    <= ST_FETCH;
                        imem_req <= issues_request(ST_FETCH);
                    end else if (!freeze) begin
                        pc       <= pc_next;
                        state    <= ST_FETCH;
                        imem_req <= issues_request(ST_FETCH);
                    end
                end
                ST_DRAIN: begin
                    // The response consumed here belongs to the old address.
                    if (branch_taken) begin
                        pc <= br_target;
                    end else if (imem_rdy) begin
                        state    <= ST_FETCH;
                        imem_req <= issues_request(ST_FETCH);
                    end
                end
                default: begin
                    state    <= ST_FETCH;
                    imem_req <= issues_request(ST_FETCH);
                end
            endcase
        end
    end

    if_fetch_unit_if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (id_load),
        .bubble    (id_bubble),
        .load_pc   (pc_next),
        .load_inst (id_inst),
        .pc        (if_pc),
        .inst      (if_inst),
        .valid     (if_valid)
    );

`ifdef IF_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Performance counters: both free-running and wrapping.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (id_load && !id_bubble) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (freeze || (state == ST_DRAIN)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule : if_fetch_unit

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed bench for if_fetch_unit. A behavioural model tracks pc, a parked
// word, an outstanding stale request and the IF/ID contents; a compare process
// checks every DUT output against it on each falling edge. Literal checks pin
// the expected values of the listed scenarios.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    // ------------------------------------------------------------------ clock/reset
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_adrs;
    logic        imem_rdy;
    logic [31:0] imem_inst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic [1:0]  dbg_state;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_adrs    (imem_adrs),
        .imem_rdy     (imem_rdy),
        .imem_inst    (imem_inst),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_valid     (if_valid),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt),
`endif
        .dbg_state    (dbg_state)
    );

    // ------------------------------------------------------------------ memory
    // Word at 4 is the literal from the plan; elsewhere {8'h13, addr[23:0]}.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'd4) return 32'h8001_060A;
        return {8'h13, a[23:0]};
    endfunction

    always_comb imem_inst = rom(imem_adrs);

    // ------------------------------------------------------------------ scoreboard
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------ model
    logic [31:0] m_pc, m_if_pc, m_if_inst, m_hold, m_fetch, m_stall;
    logic        m_valid, m_held, m_stale;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc      <= 32'd0;
            m_if_pc   <= 32'd0;
            m_if_inst <= 32'd0;
            m_valid   <= 1'b0;
            m_hold    <= 32'd0;
            m_held    <= 1'b0;
            m_stale   <= 1'b0;
            m_fetch   <= 32'd0;
            m_stall   <= 32'd0;
        end else begin : model_step
            logic [31:0] pc_n, ifpc_n, ifinst_n, hold_n;
            logic        valid_n, held_n, stale_n, loaded;
            logic [31:0] word;
            pc_n = m_pc; ifpc_n = m_if_pc; ifinst_n = m_if_inst; hold_n = m_hold;
            valid_n = m_valid; held_n = m_held; stale_n = m_stale;
            loaded = 1'b0; word = 32'd0;

            if (branch_taken) begin
                // Redirect: drop anything parked, bubble IF/ID.
                if (!m_stale) stale_n = !m_held && !imem_rdy;
                held_n   = 1'b0;
                pc_n     = {branch_addr[31:2], 2'b00};
                valid_n  = 1'b0;
                ifinst_n = 32'd0;
            end else if (m_stale) begin
                if (imem_rdy) stale_n = 1'b0;        // stale word dropped
            end else if (m_held) begin
                if (!freeze) begin
                    loaded = 1'b1; word = m_hold; held_n = 1'b0;
                end
            end else if (freeze) begin
                if (imem_rdy) begin
                    hold_n = rom(m_pc); held_n = 1'b1;
                end
            end else if (imem_rdy) begin
                loaded = 1'b1; word = rom(m_pc);
            end else begin
                valid_n  = 1'b0;
                ifinst_n = 32'd0;
            end

            if (loaded) begin
                ifpc_n   = m_pc + 32'd4;
                ifinst_n = word;
                valid_n  = 1'b1;
                pc_n     = m_pc + 32'd4;
            end

            m_pc      <= pc_n;
            m_if_pc   <= ifpc_n;
            m_if_inst <= ifinst_n;
            m_valid   <= valid_n;
            m_hold    <= hold_n;
            m_held    <= held_n;
            m_stale   <= stale_n;
            if (loaded) m_fetch <= m_fetch + 32'd1;
            if (freeze || m_stale) m_stall <= m_stall + 32'd1;
        end
    end

    // ------------------------------------------------------------------ compare
    always @(negedge clk) begin
        check("m_adrs",  64'(imem_adrs), 64'(m_pc));
        check("m_req",   64'(imem_req),  64'(!m_held));
        check("m_if_pc", 64'(if_pc),     64'(m_if_pc));
        check("m_inst",  64'(if_inst),   64'(m_if_inst));
        check("m_valid", 64'(if_valid),  64'(m_valid));
`ifdef IF_PERF_CNT_EN
        check("m_fetch_cnt", 64'(fetch_cnt), 64'(m_fetch));
        check("m_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end

    // ------------------------------------------------------------------ driver
    // Called at a falling edge; applies inputs and returns at the next one.
    task automatic cyc(input logic f, input logic b, input logic [31:0] ba, input logic r);
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        imem_rdy     = r;
        @(negedge clk);
    endtask

    typedef struct {
        logic        f;
        logic        b;
        logic [31:0] ba;
        logic        r;
    } vec_t;

    vec_t vecs[14];

    initial begin
        freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0; imem_rdy = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_adrs",  64'(imem_adrs), 64'h0);
        check("rst_req",   64'(imem_req),  64'h1);
        check("rst_valid", 64'(if_valid),  64'h0);
        check("rst_if_pc", 64'(if_pc),     64'h0);
        check("rst_inst",  64'(if_inst),   64'h0);
        rst = 1'b1;

        // Streaming from reset: adrs 0,4,8; word@4 lands with if_pc=8.
        cyc(0, 0, 0, 1);
        check("s_adrs4",  64'(imem_adrs), 64'h4);
        check("s_ifpc4",  64'(if_pc),     64'h4);
        cyc(0, 0, 0, 1);
        check("s_adrs8",  64'(imem_adrs), 64'h8);
        check("s_inst4",  64'(if_inst),   64'h8001_060A);
        check("s_ifpc8",  64'(if_pc),     64'h8);

        // rdy low two cycles at pc=8.
        cyc(0, 0, 0, 0);
        check("nr_valid", 64'(if_valid),  64'h0);
        check("nr_ifpc",  64'(if_pc),     64'h8);
        check("nr_inst",  64'(if_inst),   64'h0);
        cyc(0, 0, 0, 0);
        check("nr_adrs",  64'(imem_adrs), 64'h8);
        cyc(0, 0, 0, 1);
        check("nr_ifpc12", 64'(if_pc),    64'hC);
        check("nr_inst8",  64'(if_inst),  64'h1300_0008);

        // Freeze three cycles at pc=16.
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 1);
            check("fz_adrs", 64'(imem_adrs), 64'h10);
            check("fz_ifpc", 64'(if_pc),     64'h10);
            check("fz_inst", 64'(if_inst),   64'h1300_000C);
            check("fz_req",  64'(imem_req),  64'h0);
        end
        cyc(0, 0, 0, 1);
        check("fz_rel_inst", 64'(if_inst),   64'h1300_0010);
        check("fz_rel_ifpc", 64'(if_pc),     64'h14);
        check("fz_rel_adrs", 64'(imem_adrs), 64'h14);
        cyc(0, 0, 0, 1);
        check("fz_next_inst", 64'(if_inst),  64'h1300_0014);

        // Branch to 0x127 from pc=0x130.
        cyc(0, 1, 32'h130, 1);
        cyc(0, 1, 32'h127, 1);
        check("br_adrs",  64'(imem_adrs), 64'h124);
        check("br_valid", 64'(if_valid),  64'h0);
        check("br_ifpc",  64'(if_pc),     64'h18);
        cyc(0, 0, 0, 1);
        check("br_inst",  64'(if_inst),   64'h1300_0124);
        check("br_ifpc2", 64'(if_pc),     64'h128);

        // Branch with rdy low -> DRAIN, re-branch, stale response dropped.
        cyc(0, 1, 32'h200, 0);
        check("dr_state", 64'(dbg_state), 64'(ST_DRAIN));
        check("dr_adrs",  64'(imem_adrs), 64'h200);
        check("dr_req",   64'(imem_req),  64'h1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h300, 0);
        check("dr_state2", 64'(dbg_state), 64'(ST_DRAIN));
        check("dr_adrs2",  64'(imem_adrs), 64'h300);
        cyc(0, 0, 0, 1);
        check("dr_drop_valid", 64'(if_valid),  64'h0);
        check("dr_back_state", 64'(dbg_state), 64'(ST_FETCH));
        cyc(0, 0, 0, 1);
        check("dr_inst", 64'(if_inst), 64'h1300_0300);
        check("dr_ifpc", 64'(if_pc),   64'h304);

        // Branch and freeze together, then branch out of HOLD.
        cyc(1, 1, 32'h40, 1);
        check("bf_adrs",  64'(imem_adrs), 64'h40);
        check("bf_valid", 64'(if_valid),  64'h0);
        cyc(1, 0, 0, 1);
        check("bf_hold_req", 64'(imem_req), 64'h0);
        cyc(1, 1, 32'h80, 1);
        check("bh_adrs", 64'(imem_adrs), 64'h80);
        check("bh_req",  64'(imem_req),  64'h1);
        cyc(0, 0, 0, 1);
        check("bh_inst", 64'(if_inst), 64'h1300_0080);

        // PC wrap.
        cyc(0, 1, 32'hFFFF_FFFC, 1);
        cyc(0, 0, 0, 1);
        check("wr_ifpc",  64'(if_pc),     64'h0);
        check("wr_adrs",  64'(imem_adrs), 64'h0);
        check("wr_inst",  64'(if_inst),   64'h13FF_FFFC);
        check("wr_valid", 64'(if_valid),  64'h1);

        // Async reset while in HOLD: parked word lost.
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        #2 rst = 1'b0;
        #1;
        check("rh_req",   64'(imem_req),  64'h1);
        check("rh_valid", 64'(if_valid),  64'h0);
        check("rh_adrs",  64'(imem_adrs), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 0, 1);
        check("rh_inst", 64'(if_inst), 64'h1300_0000);
        check("rh_ifpc", 64'(if_pc),   64'h4);

        // Async reset while in DRAIN.
        cyc(0, 1, 32'h50, 0);
        #2 rst = 1'b0;
        #1;
        check("rd_state", 64'(dbg_state), 64'(ST_FETCH));
        check("rd_adrs",  64'(imem_adrs), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 0, 1);
        check("rd_valid", 64'(if_valid), 64'h1);

        // Mixed vector table, checked by the model only.
        vecs = '{
            '{0, 0, 32'h0,   1}, '{1, 0, 32'h0,   0}, '{1, 0, 32'h0,   1},
            '{0, 1, 32'h2B,  1}, '{0, 0, 32'h0,   0}, '{0, 1, 32'h99,  0},
            '{1, 0, 32'h0,   0}, '{1, 0, 32'h0,   1}, '{0, 0, 32'h0,   1},
            '{1, 0, 32'h0,   1}, '{0, 1, 32'h10,  0}, '{0, 0, 32'h0,   1},
            '{0, 0, 32'h0,   1}, '{0, 0, 32'h0,   1}
        };
        foreach (vecs[i]) cyc(vecs[i].f, vecs[i].b, vecs[i].ba, vecs[i].r);

        cyc(0, 0, 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_if_fetch_unit

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage. It is the initiator side of the instruction-memory interface. It owns the PC, drives byte addresses to instruction memory and consumes the returned words. It loads them into the IF/ID pipeline register for decode. It supports hazard freeze, branch redirect and a multi-cycle memory via a ready handshake, so either the combinational ROM (ready tied high) or a later SRAM-backed store can sit behind it.

Parameters:
ADDR_W, 32, PC / address width
DATA_W, 32, instruction width
PC_STEP, 4, byte increment per instruction
RESET_PC, 0, PC after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
freeze  in  1  hazard stall from ID; hold PC and IF/ID
branch_taken  in  1  redirect request from ID
branch_addr  in  ADDR_W  redirect target, byte address
imem_req  out  1  fetch request valid
imem_adrs  out  ADDR_W  fetch byte address (= PC)
imem_rdy  in  1  imem_inst valid this cycle for the current imem_adrs
imem_inst  in  DATA_W  returned instruction
if_pc  out  ADDR_W  PC+PC_STEP of the instruction in IF/ID
if_inst  out  DATA_W  instruction in IF/ID
if_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst low, async): pc=RESET_PC; if_pc=0, if_inst=0, if_valid=0; hold register cleared; state FETCH.
- Outputs are Moore. imem_adrs=pc always. imem_req=1 in FETCH and DRAIN, 0 in HOLD.
- pc[1:0] is always 00. branch_addr[1:0] is ignored and forced to 00. pc+PC_STEP wraps modulo 2^ADDR_W.
- NOP is all-zeros. A bubble means if_inst=0, if_valid=0 and if_pc unchanged.
- Latency: with imem_rdy tied high, the instruction at address A appears in IF/ID on the edge after pc=A, with if_pc=A+4. Throughput is 1 instruction per cycle.
- Priority per edge: branch_taken > freeze > normal.
- FETCH:
  - branch_taken: pc<=branch_addr; IF/ID<=bubble. If imem_rdy is high, next state is FETCH; otherwise DRAIN.
  - Else freeze & imem_rdy: hold<=imem_inst; IF/ID unchanged; go to HOLD.
  - Else freeze & !imem_rdy: everything unchanged.
  - Else imem_rdy: IF/ID<={pc+4, imem_inst, 1}; pc<=pc+4.
  - Else (no rdy): IF/ID<=bubble; pc unchanged.
- HOLD (captured word, waiting for decode):
  - branch_taken: discard hold; pc<=branch_addr; IF/ID<=bubble; go to FETCH.
  - Else freeze: unchanged.
  - Else: IF/ID<={pc+4, hold, 1}; pc<=pc+4; go to FETCH.
- DRAIN (stale request outstanding after redirect; imem_adrs already shows the new pc, and the memory's response to the old address is discarded):
  - Wait for imem_rdy, then go to FETCH. IF/ID stays bubble.
  - A further branch_taken updates pc and stays in DRAIN.
- Freeze and branch in the same cycle: the branch wins, and the IF/ID bubble is written despite freeze.
- Reset mid-DRAIN or mid-HOLD: immediate return to the reset state. Held data is lost.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both cleared by reset.
  - fetch_cnt increments on each IF/ID load with valid=1.
  - stall_cnt increments on each cycle in which freeze=1 or the state is DRAIN.
  - Both counters wrap.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package holds: fetch state enum {FETCH, HOLD, DRAIN}, the NOP_INST constant (32'h0), and the PC_STEP and RESET_PC defaults.
- One sub-module, if_id_reg: the IF/ID register (pc, inst, valid) with load/bubble/hold controls and async active-low clear. The FSM and PC stay in if_fetch_unit.

Test Plan:
- Reset release, imem_rdy=1, ROM returning 32'h8001060A at 4: imem_adrs steps 0,4,8. IF/ID shows inst@4 with if_pc=8, one cycle after adrs=4.
- Freeze for 3 cycles while pc=16: pc stays 16 and IF/ID is unchanged. After release, if_inst=word@16 and if_pc=20, with no duplicate or skipped fetch.
- branch_taken with branch_addr=0x127 while pc=0x130: pc=0x124 next, IF/ID is a bubble (valid=0), and the following IF/ID holds word@0x124.
- imem_rdy low for 2 cycles at pc=8: two bubbles are inserted and pc holds at 8. When rdy returns, the word@8 is loaded with if_pc=12.
- Branch while imem_rdy is low: state goes to DRAIN and the first rdy response is discarded. The next accepted word comes from the target. Branch plus freeze in the same cycle also redirects.
- pc=0xFFFFFFFC with rdy: pc wraps to 0 and if_pc=0. With IF_PERF_CNT_EN defined, check fetch_cnt and stall_cnt against the scoreboard counts.
